// File: rtl/snn_pkg.sv
// Shared definitions for the spike event encoder slice.
// Holds the event and byte widths and the output serializer state
// encoding used by the encoder top and its testbench.
package snn_pkg;

    localparam int EVENT_W = 16;
    localparam int TS_W    = 8;
    localparam int BYTE_W  = 8;

    // Output serializer states: idle, sending the timestamp byte,
    // sending the spike-mask byte.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_TS  = 2'd1,
        SEND_SPK = 2'd2
    } state_e;

endpackage

// File: rtl/spike_event_encoder_if.sv
// Byte-stream handshake bundle between the spike event encoder and the
// chip output interface.
//   out_data  : serialized event byte (encoder -> consumer)
//   out_valid : out_data is valid     (encoder -> consumer)
//   out_ready : consumer accepts byte (consumer -> encoder)
// master is the encoder side, slave is the consumer side.
interface spike_event_encoder_if;
    import snn_pkg::*;

    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/event_fifo.sv
// Circular-buffer FIFO for timestamped spike events.
// Ports:
//   clk, reset : clock and asynchronous active-low reset
//   push_i     : request to write data_i (ignored when full unless popping)
//   pop_i      : request to remove the head entry (ignored when empty)
//   data_i     : entry to write
//   data_o     : current head entry
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   level_o    : current occupancy, 0..DEPTH
module event_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_pop;
    logic             do_push;

    // A push into a full FIFO is still accepted when the head leaves on
    // the same edge, so the slot being freed is reused immediately.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Storage array needs no reset; occupancy is tracked by level_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + LW'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

endmodule

// File: rtl/spike_event_encoder.sv
// Spike event encoder: captures every enabled cycle with any neuron spike
// as a {timestamp, spike mask} event, queues it, and streams each event
// as two bytes (timestamp first) over a valid/ready handshake.
// Ports:
//   clk, reset     : clock and asynchronous active-low reset
//   enable         : capture and timestamp enable
//   spikes_in      : one spike bit per neuron
//   out_if         : byte stream (out_data/out_valid/out_ready), master side
//   overflow       : sticky flag, an event was dropped on a full FIFO
//   clear_overflow : synchronous clear of overflow and drop_count
//   drop_count     : dropped events, saturating at 255
//   fifo_level     : queued events
module spike_event_encoder
    import snn_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [N-1:0]           spikes_in,
    spike_event_encoder_if.master  out_if,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output logic [7:0]             drop_count,
    output logic [LW-1:0]          fifo_level
);

    logic [TS_W-1:0]    ts_q, ts_d;
    logic [BYTE_W-1:0]  spk_ext;
    logic [EVENT_W-1:0] head;
    logic               capture;
    logic               pop;
    logic               full;
    logic               empty;
    logic               drop;
    state_e             state_q, state_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_count_q, drop_count_d;
    logic               valid_c;
    logic [BYTE_W-1:0]  data_c;

    assign capture = enable && (spikes_in != '0);
    // The head leaves the queue once its second byte is accepted.
    assign pop     = (state_q == SEND_SPK) && out_if.out_ready;
    // full implies non-empty, so a pop here always frees a slot.
    assign drop    = capture && full && !pop;

    // Widen the spike mask to a full byte with zero upper bits.
    always_comb begin
        spk_ext = '0;
        spk_ext[N-1:0] = spikes_in;
    end

    event_fifo #(.WIDTH(EVENT_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (capture),
        .pop_i   (pop),
        .data_i  ({ts_q, spk_ext}),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    // Timestamp advances on every enabled edge and wraps at 255.
    always_comb begin
        ts_d = ts_q;
        if (enable) begin
            ts_d = ts_q + TS_W'(1);
        end
    end

    // Clear takes priority over a drop occurring on the same edge.
    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    // Serializer: after the spike byte is accepted, keep going if anything
    // remains queued after the pop, counting an event captured this edge.
    always_comb begin
        state_d = state_q;
        valid_c = 1'b0;
        data_c  = '0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = SEND_TS;
                end
            end
            SEND_TS: begin
                valid_c = 1'b1;
                data_c  = head[EVENT_W-1:BYTE_W];
                if (out_if.out_ready) begin
                    state_d = SEND_SPK;
                end
            end
            SEND_SPK: begin
                valid_c = 1'b1;
                data_c  = head[BYTE_W-1:0];
                if (out_if.out_ready) begin
                    state_d = (fifo_level > LW'(1) || capture) ? SEND_TS : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q         <= '0;
            state_q      <= IDLE;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            ts_q         <= ts_d;
            state_q      <= state_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_if.out_valid = valid_c;
    assign out_if.out_data  = data_c;
    assign overflow         = overflow_q;
    assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Self-checking bench for spike_event_encoder (N=4, DEPTH=4).
// A queue-based reference model tracks timestamps, queued events, the
// byte currently offered and the overflow bookkeeping; every cycle the
// DUT outputs are compared against it, alongside directed sequences.
module tb_spike_event_encoder;
    import snn_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] spikes_in;
    logic         clear_overflow;
    logic         overflow;
    logic [7:0]   drop_count;
    logic [2:0]   fifo_level;

    spike_event_encoder_if bus ();

    spike_event_encoder #(.N(N), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .spikes_in      (spikes_in),
        .out_if         (bus.master),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .drop_count     (drop_count),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int          mTs;
    logic [15:0] mQ[$];
    bit          mActive;
    bit          mHalf;
    bit          mOvf;
    int          mDrops;

    logic [7:0]  recv[$];

    typedef struct {
        bit         en;
        logic [3:0] sp;
        bit         rdy;
        bit         expValid;
        logic [7:0] expData;
        int         expLevel;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mTs = 0;
        mQ.delete();
        mActive = 0;
        mHalf = 0;
        mOvf = 0;
        mDrops = 0;
    endtask

    // One rising edge of the specified behaviour.
    task automatic modelStep(input bit en, input logic [3:0] sp, input bit rdy, input bit clr);
        bit   hs;
        bit   popNow;
        bit   drop;
        int   preSize;
        logic [7:0] spk8;
        hs      = mActive && rdy;
        popNow  = hs && mHalf;
        preSize = mQ.size();
        drop    = 0;
        spk8    = 8'(sp);
        if (popNow) void'(mQ.pop_front());
        if (en && sp != 0) begin
            if (preSize < DEPTH || popNow) mQ.push_back({8'(mTs), spk8});
            else drop = 1;
        end
        if (clr) begin
            mOvf = 0;
            mDrops = 0;
        end else if (drop) begin
            mOvf = 1;
            if (mDrops < 255) mDrops++;
        end
        if (en) mTs = (mTs + 1) % 256;
        if (hs) begin
            if (mHalf) begin
                mHalf = 0;
                mActive = (mQ.size() > 0);
            end else begin
                mHalf = 1;
            end
        end else if (!mActive) begin
            mActive = (preSize > 0);
        end
    endtask

    task automatic checkModel();
        logic [15:0] h;
        int expData;
        expData = 0;
        if (mActive) begin
            h = mQ[0];
            expData = mHalf ? int'(h[7:0]) : int'(h[15:8]);
        end
        checkOutput("out_valid", int'(bus.out_valid), int'(mActive));
        checkOutput("out_data", int'(bus.out_data), expData);
        checkOutput("fifo_level", int'(fifo_level), mQ.size());
        checkOutput("overflow", int'(overflow), int'(mOvf));
        checkOutput("drop_count", int'(drop_count), mDrops);
    endtask

    // Drive one cycle, record any accepted byte, then check against the model.
    task automatic applyStimulus(input bit en, input logic [3:0] sp, input bit rdy, input bit clr);
        enable = en;
        spikes_in = sp;
        bus.out_ready = rdy;
        clear_overflow = clr;
        #1;
        if (bus.out_valid && rdy) recv.push_back(bus.out_data);
        @(posedge clk);
        modelStep(en, sp, rdy, clr);
        #1;
        checkModel();
    endtask

    task automatic drainAll();
        int n;
        n = 0;
        while ((mQ.size() > 0 || mActive) && n < 40) begin
            applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
            n++;
        end
        if (n >= 40) checkOutput("drain timeout", 1, 0);
    endtask

    task automatic advanceTo(input int target);
        int n;
        n = 0;
        while (mTs != target && n < 300) begin
            applyStimulus(1'b1, 4'h0, 1'b1, 1'b0);
            n++;
        end
        if (n >= 300) checkOutput("advance timeout", 1, 0);
    endtask

    task automatic checkRecv(input string name, input logic [7:0] exp[$]);
        checkOutput({name, " count"}, recv.size(), exp.size());
        for (int i = 0; i < exp.size() && i < recv.size(); i++) begin
            checkOutput($sformatf("%s byte%0d", name, i), int'(recv[i]), int'(exp[i]));
        end
    endtask

    initial begin
        int t0;
        int tsFrozen;
        int cyc;
        logic [7:0] exp[$];

        reset = 1'b0;
        enable = 1'b0;
        spikes_in = '0;
        clear_overflow = 1'b0;
        bus.out_ready = 1'b0;
        modelReset();
        #12;
        checkOutput("reset out_valid", int'(bus.out_valid), 0);
        checkOutput("reset out_data", int'(bus.out_data), 0);
        checkOutput("reset fifo_level", int'(fifo_level), 0);
        checkOutput("reset overflow", int'(overflow), 0);
        checkOutput("reset drop_count", int'(drop_count), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single event at ts=3, consumer always ready
        vecs[0] = '{1, 4'h0, 1, 0, 8'h00, 0};
        vecs[1] = '{1, 4'h0, 1, 0, 8'h00, 0};
        vecs[2] = '{1, 4'h0, 1, 0, 8'h00, 0};
        vecs[3] = '{1, 4'h5, 1, 0, 8'h00, 1};
        vecs[4] = '{1, 4'h0, 1, 1, 8'h03, 1};
        vecs[5] = '{1, 4'h0, 1, 1, 8'h05, 1};
        vecs[6] = '{1, 4'h0, 1, 0, 8'h00, 0};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].en, vecs[i].sp, vecs[i].rdy, 1'b0);
            checkOutput($sformatf("vec%0d valid", i), int'(bus.out_valid), int'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d data", i), int'(bus.out_data), int'(vecs[i].expData));
            checkOutput($sformatf("vec%0d level", i), int'(fifo_level), vecs[i].expLevel);
        end

        // Stall: three events, consumer holds off for 20 cycles
        drainAll();
        advanceTo(10);
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h8, 1'b0, 1'b0);
        recv.delete();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 4'h0, 1'b0, 1'b0);
            checkOutput("stall valid", int'(bus.out_valid), 1);
            checkOutput("stall data", int'(bus.out_data), 8'h0A);
        end
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'h0, 1'b1, 1'b0);
        exp = '{8'h0A, 8'h01, 8'h0B, 8'h02, 8'h0C, 8'h08};
        checkRecv("stall stream", exp);

        // Overflow: six spikes into a 4-deep FIFO with no consumer
        drainAll();
        t0 = mTs;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'(i + 1), 1'b0, 1'b0);
        checkOutput("ovf level", int'(fifo_level), 4);
        checkOutput("ovf flag", int'(overflow), 1);
        checkOutput("ovf drops", int'(drop_count), 2);
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b1);
        checkOutput("clear flag", int'(overflow), 0);
        checkOutput("clear drops", int'(drop_count), 0);
        recv.delete();
        drainAll();
        exp.delete();
        for (int i = 0; i < 4; i++) begin
            exp.push_back(8'((t0 + i) % 256));
            exp.push_back(8'(i + 1));
        end
        checkRecv("ovf drain", exp);

        // Timestamp wrap
        drainAll();
        advanceTo(255);
        recv.delete();
        applyStimulus(1'b1, 4'h3, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'h6, 1'b1, 1'b0);
        drainAll();
        exp = '{8'hFF, 8'h03, 8'h00, 8'h06};
        checkRecv("wrap", exp);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 40) == 0);
        end

        // enable=0 freezes capture and timestamp but not the output
        drainAll();
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b1);
        recv.delete();
        t0 = mTs;
        applyStimulus(1'b1, 4'h9, 1'b0, 1'b0);
        tsFrozen = (t0 + 1) % 256;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'hF, 1'b0, 1'b0);
        checkOutput("disabled level", int'(fifo_level), 1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 4'hF, 1'b1, 1'b0);
        checkOutput("disabled drained", int'(fifo_level), 0);
        applyStimulus(1'b1, 4'h5, 1'b1, 1'b0);
        drainAll();
        exp = '{8'(t0), 8'h09, 8'(tsFrozen), 8'h05};
        checkRecv("disabled", exp);

        // Reset in the middle of an event
        drainAll();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'(1 << i), 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0);
        checkOutput("pre-reset data", int'(bus.out_data), 8'h01);
        checkOutput("pre-reset level", int'(fifo_level), 3);
        bus.out_ready = 1'b0;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput("mid reset valid", int'(bus.out_valid), 0);
        checkOutput("mid reset level", int'(fifo_level), 0);
        checkOutput("mid reset data", int'(bus.out_data), 0);
        #3;
        reset = 1'b1;
        recv.delete();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'h0, 1'b1, 1'b0);
            checkOutput("post-reset valid", int'(bus.out_valid), 0);
        end
        checkOutput("post-reset bytes", recv.size(), 0);
        applyStimulus(1'b1, 4'h3, 1'b1, 1'b0);
        cyc = 0;
        drainAll();
        exp = '{8'h05, 8'h03};
        checkRecv("post-reset", exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spike_event_encoder.md
Name: spike_event_encoder

Overview:
- Sits directly downstream of a bank of N delay-equipped LIF neurons and consumes their spike_out lines.
- Each enabled cycle in which any neuron fires is captured as a timestamped event in a small FIFO.
- Events are serialized as a 2-byte stream over a valid/ready handshake to the chip output interface.
- Overflow is flagged, and dropped events are counted.

Parameters:
- N, 4, number of neuron spike inputs (1..8).
- DEPTH, 4, event FIFO depth in entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock, shared with the neurons.
- reset  input  1  asynchronous reset, active-low (asserted when 0).
- enable  input  1  capture and timestamp enable; same signal that drives the neuron bank.
- spikes_in  input  N  spike_out of neurons 0..N-1, one bit per neuron.
- out_data  output  8  serialized event byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the byte when out_valid && out_ready at a rising edge.
- overflow  output  1  sticky: an event was dropped.
- clear_overflow  input  1  synchronous clear of overflow and drop_count.
- drop_count  output  8  number of dropped events, saturating at 255.
- fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, async):
  - timestamp=0, FIFO empty, fifo_level=0, state=IDLE.
  - out_valid=0, out_data=0, overflow=0, drop_count=0.
- Timestamp:
  - 8-bit counter, increments on every rising edge with enable=1.
  - Wraps 255→0. Holds while enable=0.
- Capture (each edge with enable=1 and spikes_in≠0):
  - Push event {ts, spk}, where ts = counter value before that edge's increment and spk = spikes_in zero-extended to 8 bits.
  - enable=0 → no capture, even if spikes_in≠0.
  - spikes_in=0 → no event.
- FIFO: circular buffer of DEPTH 16-bit entries with wrapping read/write pointers.
  - Push when full is dropped; no entry is overwritten.
  - A dropped push sets overflow=1 and increments drop_count (saturating at 255).
  - Exception: if the head entry is popped on the same edge as a push to a full FIFO, the push is accepted and the level stays DEPTH.
- Output FSM: states IDLE, SEND_TS, SEND_SPK.
  - IDLE: out_valid=0. Go to SEND_TS at the next edge if fifo_level>0.
  - SEND_TS: out_valid=1, out_data=head.ts. On handshake go to SEND_SPK.
  - SEND_SPK: out_valid=1, out_data=head.spk. On handshake, pop the head; go to SEND_TS if fifo_level after the pop is >0, else IDLE.
  - out_data in IDLE = 0.
  - out_valid and out_data stay stable while out_valid=1 and out_ready=0. The FSM never retracts valid.
- Latency: spike sampled at edge k → out_valid=1 with the ts byte after edge k+1, if the FIFO was empty and the FSM was in IDLE.
  - Back-to-back throughput: 2 cycles per event with out_ready held at 1.
- enable=0 does not stall the output; the FIFO keeps draining.
- clear_overflow=1 at an edge clears overflow and drop_count. If a drop occurs on the same edge, clear wins: overflow=0 and drop_count=0.
- Reset mid-transfer discards all queued events; no partial event is emitted after reset is released.

Decomposition:
- Shared package snn_pkg:
  - EVENT_W=16, TS_W=8, BYTE_W=8.
  - FSM state enum: IDLE, SEND_TS, SEND_SPK.
- One sub-module: event_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level; same clk and reset).
- Timestamp counter, drop logic and FSM live in the top.

Test Plan:
- Reset, then enable=1, spikes_in=4'b0101 for one cycle at ts=3, out_ready=1.
  → 2 cycles later bytes 0x03 then 0x05, then out_valid=0, fifo_level=0.
- Spikes at ts=10, 11, 12 (0x1, 0x2, 0x8) with out_ready=0 for 20 cycles, then 1.
  → out_data held at 0x0A during the stall.
  → Stream 0x0A,0x01,0x0B,0x02,0x0C,0x08 on consecutive cycles.
- out_ready=0, six consecutive spike cycles with DEPTH=4.
  → fifo_level=4, overflow=1, drop_count=2.
  → Pulse clear_overflow → both cleared; the queued 4 events still drain intact.
- Timestamp wrap: enable held for 256 cycles, spike at count 255 and at the next cycle.
  → Events carry ts 0xFF then 0x00.
- enable=0 while spikes_in=0xF.
  → No events, timestamp frozen.
  → Pending events still drain when out_ready=1.
- Assert reset while in SEND_SPK with 3 queued events.
  → out_valid=0 and fifo_level=0 immediately.
  → After release, out_valid stays 0 until a new spike arrives.
